core_run_ctrl: RTL and testbench

//   Run controller that sits between the bench/top level and a RISC-V core (monocycle or later).
//   - Sequences core reset release and loads the start PC.
//   - Gates core execution: free-run, or single-step one retired instruction per step pulse.
//   - Counts cycles and retired instructions.
//   - Halts on trap, external halt request or cycle limit.
//   - Emits a registered one-cycle trace strobe (tr) with the retired PC.

---
 rtl/core_run_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_core_run_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : core_run_ctrl
//  Description : Run controller for a RISC-V core. It releases the core
//                reset, loads the start PC, and runs the core freely or one
//                instruction per step. It counts RUN cycles and retired
//                instructions, halts on trap, halt request or cycle limit,
//                and emits a one-cycle trace strobe for each retired PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_run_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32,
   parameter int RST_CYCLES = 2,
   parameter bit TRACE_EN   = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] initial_address,
   input  logic                  step_mode,
   input  logic                  step,
   input  logic                  halt_req,
   input  logic [CNT_WIDTH-1:0]  cycle_limit,
   input  logic                  retire,
   input  logic [ADDR_WIDTH-1:0] retire_pc,
   input  logic                  trap,
   output logic                  core_rst,
   output logic                  core_en,
   output logic [ADDR_WIDTH-1:0] core_pc_init,
   output logic                  running,
   output logic                  halted,
   output logic [1:0]            halt_cause,
   output logic [CNT_WIDTH-1:0]  cycle_count,
   output logic [CNT_WIDTH-1:0]  instr_count,
   output logic                  tr,
   output logic [ADDR_WIDTH-1:0] trace_pc
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_HOLD  = 3'd1;
   localparam logic [2:0] c_RUN   = 3'd2;
   localparam logic [2:0] c_PAUSE = 3'd3;
   localparam logic [2:0] c_HALT  = 3'd4;

   localparam logic [1:0] c_CAUSE_NONE  = 2'd0;
   localparam logic [1:0] c_CAUSE_TRAP  = 2'd1;
   localparam logic [1:0] c_CAUSE_REQ   = 2'd2;
   localparam logic [1:0] c_CAUSE_LIMIT = 2'd3;

   // Hold counter runs 0 .. RST_CYCLES-1 while the core is kept in reset.
   localparam int c_HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RST_CYCLES - 1);

   logic [2:0]            r_state;
   logic [c_HOLD_W-1:0]   r_hold_cnt;
   logic [ADDR_WIDTH-1:0] r_pc_init;
   logic [1:0]            r_cause;
   logic [CNT_WIDTH-1:0]  r_cycle;
   logic [CNT_WIDTH-1:0]  r_instr;

   logic [CNT_WIDTH:0]    w_cyc_p1;
   logic                  w_limit_hit;
   logic                  w_run_halt;
   logic [1:0]            w_run_cause;
   logic                  w_start_ok;

   // One extra bit so the limit compare cannot wrap at the saturated count.
   assign w_cyc_p1    = {1'b0, r_cycle} + {{CNT_WIDTH{1'b0}}, 1'b1};
   assign w_limit_hit = (cycle_limit != '0) && (w_cyc_p1 >= {1'b0, cycle_limit});
   assign w_start_ok  = start && ((r_state == c_IDLE) || (r_state == c_HALT));

   // Halt decision for a RUN cycle, priority trap > halt_req > cycle limit.
   always_comb begin
      w_run_halt  = 1'b1;
      w_run_cause = c_CAUSE_NONE;
      if (trap) begin
         w_run_cause = c_CAUSE_TRAP;
      end else if (halt_req) begin
         w_run_cause = c_CAUSE_REQ;
      end else if (w_limit_hit) begin
         w_run_cause = c_CAUSE_LIMIT;
      end else begin
         w_run_halt = 1'b0;
      end
   end

   // Run state machine, start-PC latch, halt cause and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= c_IDLE;
         r_hold_cnt <= '0;
         r_pc_init  <= '0;
         r_cause    <= c_CAUSE_NONE;
         r_cycle    <= '0;
         r_instr    <= '0;
      end else if (w_start_ok) begin
         // Fresh run from IDLE or HALT: everything restarts from zero.
         r_state    <= c_HOLD;
         r_hold_cnt <= '0;
         r_pc_init  <= initial_address;
         r_cause    <= c_CAUSE_NONE;
         r_cycle    <= '0;
         r_instr    <= '0;
      end else begin
         case (r_state)
            c_HOLD: begin
               if (r_hold_cnt == c_HOLD_LAST) begin
                  r_state <= c_RUN;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            c_RUN: begin
               if (r_cycle != '1) begin
                  r_cycle <= r_cycle + 1'b1;
               end
               // A retire in the halting cycle is still counted.
               if (retire && (r_instr != '1)) begin
                  r_instr <= r_instr + 1'b1;
               end
               if (w_run_halt) begin
                  r_state <= c_HALT;
                  r_cause <= w_run_cause;
               end else if (step_mode && retire) begin
                  r_state <= c_PAUSE;
               end
            end
            c_PAUSE: begin
               if (halt_req) begin
                  r_state <= c_HALT;
                  r_cause <= c_CAUSE_REQ;
               end else if (step || !step_mode) begin
                  r_state <= c_RUN;
               end
            end
            default: begin
               // IDLE and HALT wait for start; nothing changes here.
               r_state <= r_state;
            end
         endcase
      end
   end

   generate
      if (TRACE_EN) begin : g_trace
         logic                  r_tr;
         logic [ADDR_WIDTH-1:0] r_trace_pc;

         // Trace strobe one cycle after each retire seen in RUN.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_tr       <= 1'b0;
               r_trace_pc <= '0;
            end else begin
               r_tr <= retire && (r_state == c_RUN);
               if (retire && (r_state == c_RUN)) begin
                  r_trace_pc <= retire_pc;
               end
            end
         end

         assign tr       = r_tr;
         assign trace_pc = r_trace_pc;
      end else begin : g_no_trace
         assign tr       = 1'b0;
         assign trace_pc = '0;
      end
   endgenerate

   assign core_rst     = (r_state == c_IDLE) || (r_state == c_HOLD);
   assign core_en      = (r_state == c_RUN);
   assign running      = (r_state == c_RUN);
   assign halted       = (r_state == c_HALT);
   assign core_pc_init = r_pc_init;
   assign halt_cause   = r_cause;
   assign cycle_count  = r_cycle;
   assign instr_count  = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_run_ctrl
//  Description : Self-checking bench for core_run_ctrl. Trace strobes are
//                checked against a queue of expected PCs by a monitor;
//                control and counter outputs are checked after each step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_run_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] initial_address;
   logic        step_mode;
   logic        step;
   logic        halt_req;
   logic [31:0] cycle_limit;
   logic        retire;
   logic [31:0] retire_pc;
   logic        trap;
   logic        core_rst;
   logic        core_en;
   logic [31:0] core_pc_init;
   logic        running;
   logic        halted;
   logic [1:0]  halt_cause;
   logic [31:0] cycle_count;
   logic [31:0] instr_count;
   logic        tr;
   logic [31:0] trace_pc;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   core_run_ctrl #(
      .ADDR_WIDTH(32), .CNT_WIDTH(32), .RST_CYCLES(2), .TRACE_EN(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .initial_address(initial_address),
      .step_mode(step_mode), .step(step), .halt_req(halt_req),
      .cycle_limit(cycle_limit), .retire(retire), .retire_pc(retire_pc),
      .trap(trap), .core_rst(core_rst), .core_en(core_en),
      .core_pc_init(core_pc_init), .running(running), .halted(halted),
      .halt_cause(halt_cause), .cycle_count(cycle_count),
      .instr_count(instr_count), .tr(tr), .trace_pc(trace_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every trace strobe must match the oldest expected PC.
   always @(negedge clk) begin
      if (!reset && tr === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL trace_unexpected: got pc 0x%0h expected no strobe", trace_pc);
         end else begin
            chk("trace_pc", trace_pc, exp_q.pop_front());
         end
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; initial_address = '0; step_mode = 1'b0;
      step = 1'b0; halt_req = 1'b0; cycle_limit = '0; retire = 1'b0;
      retire_pc = '0; trap = 1'b0;

      // T1: reset state
      tick(); tick();
      chk("rst_core_rst", {31'b0, core_rst}, 32'd1);
      chk("rst_core_en", {31'b0, core_en}, 32'd0);
      chk("rst_cycles", cycle_count, 32'd0);
      chk("rst_instrs", instr_count, 32'd0);
      chk("rst_tr", {31'b0, tr}, 32'd0);
      chk("rst_flags", {29'b0, running, halted, halt_cause != 2'd0}, 32'd0);
      reset = 1'b0;

      // T2: start at 0x100, two hold cycles, running on the third
      initial_address = 32'h100; cycle_limit = 32'd5; start = 1'b1;
      tick(); start = 1'b0;
      chk("hold1_rst", {31'b0, core_rst}, 32'd1);
      chk("hold1_en", {31'b0, core_en}, 32'd0);
      chk("pc_init_100", core_pc_init, 32'h100);
      tick();
      chk("hold2_rst", {31'b0, core_rst}, 32'd1);
      tick();
      chk("run_running", {31'b0, running}, 32'd1);
      chk("run_rst_low", {31'b0, core_rst}, 32'd0);
      chk("run_en", {31'b0, core_en}, 32'd1);

      // T3: free run with a retire every cycle, cycle limit 5
      for (int i = 0; i < 5; i++) begin
         retire = 1'b1; retire_pc = 32'h100 + 32'(4 * i);
         exp_q.push_back(retire_pc);
         tick();
      end
      retire = 1'b0;
      chk("lim_halted", {31'b0, halted}, 32'd1);
      chk("lim_cause", {30'b0, halt_cause}, 32'd3);
      chk("lim_cycles", cycle_count, 32'd5);
      chk("lim_instrs", instr_count, 32'd5);
      chk("lim_en_off", {31'b0, core_en}, 32'd0);
      tick();
      chk("halt_hold_cycles", cycle_count, 32'd5);

      // T4: restart in step mode, three step pulses
      initial_address = 32'h200; cycle_limit = '0; step_mode = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      chk("restart_cycles_clr", cycle_count, 32'd0);
      chk("restart_cause_clr", {30'b0, halt_cause}, 32'd0);
      tick(); tick();
      chk("step_run", {31'b0, running}, 32'd1);
      retire = 1'b1; retire_pc = 32'h200; exp_q.push_back(retire_pc);
      tick(); retire = 1'b0;
      chk("pause_instrs", instr_count, 32'd1);
      chk("pause_en", {31'b0, core_en}, 32'd0);
      tick();
      chk("pause_frozen", cycle_count, 32'd1);
      for (int k = 1; k <= 3; k++) begin
         step = 1'b1; tick(); step = 1'b0;
         chk("step_en_on", {31'b0, core_en}, 32'd1);
         retire = 1'b1; retire_pc = 32'h200 + 32'(4 * k); exp_q.push_back(retire_pc);
         tick(); retire = 1'b0;
         chk("step_instrs", instr_count, 32'(1 + k));
         chk("step_en_off", {31'b0, core_en}, 32'd0);
      end
      chk("step_cycles", cycle_count, 32'd4);

      // T5: retire and trap together at 0x20
      step = 1'b1; tick(); step = 1'b0;
      retire = 1'b1; trap = 1'b1; retire_pc = 32'h20; exp_q.push_back(retire_pc);
      tick(); retire = 1'b0; trap = 1'b0;
      chk("trap_halted", {31'b0, halted}, 32'd1);
      chk("trap_cause", {30'b0, halt_cause}, 32'd1);
      chk("trap_instrs", instr_count, 32'd5);

      // T6: halt_req beats step in PAUSE
      initial_address = 32'h300; start = 1'b1;
      tick(); start = 1'b0; tick(); tick();
      chk("pc_init_300", core_pc_init, 32'h300);
      retire = 1'b1; retire_pc = 32'h300; exp_q.push_back(retire_pc);
      tick(); retire = 1'b0;
      halt_req = 1'b1; step = 1'b1;
      tick(); halt_req = 1'b0; step = 1'b0;
      chk("req_halted", {31'b0, halted}, 32'd1);
      chk("req_cause", {30'b0, halt_cause}, 32'd2);
      chk("req_instrs", instr_count, 32'd1);

      // Restart at 0x0: counters cleared, back through HOLD
      initial_address = 32'h0; step_mode = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      chk("r0_core_rst", {31'b0, core_rst}, 32'd1);
      chk("r0_instrs", instr_count, 32'd0);
      chk("r0_cycles", cycle_count, 32'd0);
      chk("r0_pc_init", core_pc_init, 32'h0);
      tick(); tick();
      chk("r0_running", {31'b0, running}, 32'd1);

      // start ignored in RUN; halt_req in RUN gives cause 2
      initial_address = 32'h999; start = 1'b1;
      tick(); start = 1'b0;
      chk("ign_running", {31'b0, running}, 32'd1);
      chk("ign_pc_init", core_pc_init, 32'h0);
      halt_req = 1'b1; tick(); halt_req = 1'b0;
      chk("run_req_cause", {30'b0, halt_cause}, 32'd2);
      chk("run_req_cycles", cycle_count, 32'd2);

      // Reset mid-run aborts immediately
      start = 1'b1; tick(); start = 1'b0; tick(); tick();
      retire = 1'b1; retire_pc = 32'h4; exp_q.push_back(retire_pc);
      tick(); retire = 1'b0;
      tick();
      reset = 1'b1; tick();
      chk("abort_rst", {31'b0, core_rst}, 32'd1);
      chk("abort_en", {31'b0, core_en}, 32'd0);
      chk("abort_instrs", instr_count, 32'd0);
      reset = 1'b0;
      tick(); tick();
      chk("trace_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
